trisc_datapath: RTL and testbench
=================================

# trisc_datapath

Execution datapath of the TRISC Part A processor, responding to the accumulator controller's one-hot control word. It holds PC, MAR, MDR, IR, the accumulator and a 16-word program memory. Each register acts on the control bit asserted during the preceding cycle. IR is decoded into the INCA/CLRA status lines the controller samples at the end of its decode state.

## Interface
- ADDR_W, 4: PC/MAR width; memory depth 2^ADDR_W
- DATA_W, 8: memory word, MDR, IR and ACC width
- OPC_INC, 4'h1: IR[7:4] value that decodes to INCA
- OPC_CLR, 4'h2: IR[7:4] value that decodes to CLRA

Ports (reset CLR, asynchronous, active-high; clock clk):
- clk  in  1  clock, all state changes on rising edge
- CLR  in  1  async reset, active-high
- C0  in  1  synchronous clear of PC, MAR, MDR, IR, ACC, CY
- C2  in  1  PC <= PC+1
- C3  in  1  MAR <= PC
- C4  in  1  MDR <= MEM[MAR]
- C42  in  1  IR <= MDR
- C7  in  1  decode enable for INCA/CLRA
- C8  in  1  ACC <= 0, CY <= 0
- C9  in  1  ACC <= ACC+1
- ld_en  in  1  program-load write strobe
- ld_addr  in  ADDR_W  program-load address
- ld_data  in  DATA_W  program-load data
- INCA  out  1  combinational: C7 & (IR[7:4]==OPC_INC)
- CLRA  out  1  combinational: C7 & (IR[7:4]==OPC_CLR)
- acc  out  DATA_W  accumulator
- cy  out  1  sticky accumulator carry
- pc  out  ADDR_W  program counter
- ir  out  DATA_W  instruction register

## Operation
- CLR high: PC, MAR, MDR, IR, ACC, CY all 0 immediately. INCA=CLRA=0 because IR=0. Memory contents not reset.
- Memory: 2^ADDR_W x DATA_W array. On an edge with ld_en, MEM[ld_addr] <= ld_data. Writes are allowed at any time, including while running.
- Read-before-write: C4 and ld_en to the same address on the same edge load the old word into MDR.
- Priority per edge: C0 overrides every other control bit. C8 overrides C9 for ACC/CY. All other bits are independent; C2 with C7 is the normal decode-cycle combination.
- PC increments modulo 2^ADDR_W; 15 -> 0 with defaults.
- ACC increments modulo 2^DATA_W. On the 255 -> 0 wrap, CY <= 1. CY stays 1 until C0, C8 or CLR.
- Any opcode other than OPC_INC/OPC_CLR is a NOP: INCA=CLRA=0. IR[3:0] is ignored in Part A.
- INCA and CLRA are never both 1, since OPC_INC differs from OPC_CLR.
- With no control bit asserted, every register holds.

## Timing
- Controller outputs are Moore signals from its state. The datapath register updates on the edge ending the state that asserts the control bit.
- Fetch sequence:
  - B (C3): MAR valid after edge 1.
  - C (C4): MDR valid after edge 2.
  - D (C42): IR valid after edge 3.
  - E (C2, C7): PC+1 after edge 4. INCA/CLRA valid combinationally during E, derived from the IR loaded at edge 3.
  - F (C9) or G (C8): ACC updated after edge 5.
- Instruction latency: 5 edges from B to ACC update; 4 edges for a NOP, B->C->D->E->B.
- INCA/CLRA must settle within the cycle of C7, with no register in the path.
- CLR asserted mid-instruction clears all registers at once. Deassertion takes effect synchronously at the next clk edge; no partial update may survive.

## Test plan
- Reset: pulse CLR mid-cycle with ACC=8'h37, PC=5 -> pc=0, acc=0, cy=0, ir=0, INCA=CLRA=0 before the next edge.
- INC program: load MEM[0..2]=8'h10, MEM[3]=8'h20, then run the A,B,C,D,E,F/G sequence -> acc=1,2,3 after each F, then 0 after the G for MEM[3]; pc=4; INCA high only during each E of the first three instructions.
- Wrap: preset ACC=8'hFF via repeated C9, assert C9 once -> acc=0, cy=1. Assert C8 -> cy=0. Step PC from 15 with C2 -> pc=0.
- Priority: assert C0 and C9 together with acc=4 -> acc=0. Assert C8 and C9 together -> acc=0.
- Read/write collision: MEM[2]=8'h10, MAR=2, assert C4 with ld_en, ld_addr=2, ld_data=8'h20 -> MDR=8'h10, next C4 gives 8'h20.
- NOP decode: IR=8'h30 with C7 high -> INCA=CLRA=0; ACC unchanged over the whole instruction.

Source files
------------

// File: rtl/trisc_datapath.sv
// TRISC Part A execution datapath: PC, MAR, MDR, IR, accumulator and program memory,
// driven by the one-hot control word of the accumulator controller.
module trisc_datapath #(
    parameter int          ADDR_W  = 4,
    parameter int          DATA_W  = 8,
    parameter logic [3:0]  OPC_INC = 4'h1,
    parameter logic [3:0]  OPC_CLR = 4'h2
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic              C0,
    input  logic              C2,
    input  logic              C3,
    input  logic              C4,
    input  logic              C42,
    input  logic              C7,
    input  logic              C8,
    input  logic              C9,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              INCA,
    output logic              CLRA,
    output logic [DATA_W-1:0] acc,
    output logic              cy,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_STEP  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ACC_STEP = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ACC_MAX  = {DATA_W{1'b1}};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] mar_r;
    logic [DATA_W-1:0] mdr_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] acc_r;
    logic              cy_r;
    logic [3:0]        opc_s;

    // Program-load write port; contents are deliberately untouched by CLR
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    // Fetch-path registers; MDR samples the pre-write word on a same-edge load
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            pc_r  <= '0;
            mar_r <= '0;
            mdr_r <= '0;
            ir_r  <= '0;
        end else if (C0) begin
            pc_r  <= '0;
            mar_r <= '0;
            mdr_r <= '0;
            ir_r  <= '0;
        end else begin
            if (C2)  pc_r  <= pc_r + PC_STEP;
            if (C3)  mar_r <= pc_r;
            if (C4)  mdr_r <= mem_r[mar_r];
            if (C42) ir_r  <= mdr_r;
        end
    end

    // Accumulator with sticky carry; clear wins over increment
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            acc_r <= '0;
            cy_r  <= 1'b0;
        end else if (C0 || C8) begin
            acc_r <= '0;
            cy_r  <= 1'b0;
        end else if (C9) begin
            acc_r <= acc_r + ACC_STEP;
            if (acc_r == ACC_MAX) begin
                cy_r <= 1'b1;
            end
        end
    end

    // Decode must be combinational so the controller sees it within the C7 cycle
    assign opc_s = ir_r[DATA_W-1 -: 4];
    assign INCA  = C7 && (opc_s == OPC_INC);
    assign CLRA  = C7 && (opc_s == OPC_CLR);

    assign acc = acc_r;
    assign cy  = cy_r;
    assign pc  = pc_r;
    assign ir  = ir_r;

endmodule

// File: tb/tb_trisc_datapath.sv
// Scoreboard bench for trisc_datapath: stimulus pushes expected observations from a
// behavioural model, a monitor pops and compares them each cycle.
module tb_trisc_datapath;

    localparam logic [7:0] K_C0  = 8'h01;
    localparam logic [7:0] K_C2  = 8'h02;
    localparam logic [7:0] K_C3  = 8'h04;
    localparam logic [7:0] K_C4  = 8'h08;
    localparam logic [7:0] K_C42 = 8'h10;
    localparam logic [7:0] K_C7  = 8'h20;
    localparam logic [7:0] K_C8  = 8'h40;
    localparam logic [7:0] K_C9  = 8'h80;

    logic       clk;
    logic       CLR;
    logic       C0, C2, C3, C4, C42, C7, C8, C9;
    logic       ld_en;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       INCA, CLRA;
    logic [7:0] acc;
    logic       cy;
    logic [3:0] pc;
    logic [7:0] ir;

    trisc_datapath dut (
        .clk(clk), .CLR(CLR),
        .C0(C0), .C2(C2), .C3(C3), .C4(C4), .C42(C42), .C7(C7), .C8(C8), .C9(C9),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .INCA(INCA), .CLRA(CLRA), .acc(acc), .cy(cy), .pc(pc), .ir(ir)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] pc;
        logic [7:0] acc;
        logic       cy;
        logic [7:0] ir;
        logic       inca;
        logic       clra;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Reference machine state kept as plain integers
    int m_pc, m_mar, m_mdr, m_ir, m_acc, m_cy;
    int m_mem [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample mid-cycle, well away from the rising edge
    always @(negedge clk) begin
        #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("pc",   int'(pc),   int'(mon_e.pc));
            chk("acc",  int'(acc),  int'(mon_e.acc));
            chk("cy",   int'(cy),   int'(mon_e.cy));
            chk("ir",   int'(ir),   int'(mon_e.ir));
            chk("INCA", int'(INCA), int'(mon_e.inca));
            chk("CLRA", int'(CLRA), int'(mon_e.clra));
        end
    end

    task automatic model_clear();
        m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_acc = 0; m_cy = 0;
    endtask

    // What one rising edge does to the machine, given the control bits held this cycle
    task automatic model_edge(input logic [7:0] ctl, input logic le, input int la,
                              input int ldt, input logic clr);
        int word;
        int n_pc, n_mar, n_mdr, n_ir;
        word = m_mem[m_mar];
        if (le) m_mem[la] = ldt;
        if (clr || ctl[0]) begin
            model_clear();
            return;
        end
        n_pc  = ctl[1] ? (m_pc + 1) % 16 : m_pc;
        n_mar = ctl[2] ? m_pc : m_mar;
        n_mdr = ctl[3] ? word : m_mdr;
        n_ir  = ctl[4] ? m_mdr : m_ir;
        m_pc = n_pc; m_mar = n_mar; m_mdr = n_mdr; m_ir = n_ir;
        if (ctl[6]) begin
            m_acc = 0;
            m_cy  = 0;
        end else if (ctl[7]) begin
            if (m_acc == 255) m_cy = 1;
            m_acc = (m_acc + 1) % 256;
        end
    endtask

    task automatic cyx(input logic [7:0] ctl, input logic le, input logic [3:0] la,
                       input logic [7:0] ldt, input logic clr);
        exp_t e;
        @(negedge clk);
        CLR = clr;
        C0 = ctl[0]; C2 = ctl[1]; C3 = ctl[2]; C4 = ctl[3];
        C42 = ctl[4]; C7 = ctl[5]; C8 = ctl[6]; C9 = ctl[7];
        ld_en = le; ld_addr = la; ld_data = ldt;
        if (clr) model_clear();
        e.pc   = 4'(m_pc);
        e.acc  = 8'(m_acc);
        e.cy   = (m_cy != 0);
        e.ir   = 8'(m_ir);
        e.inca = ctl[5] && (m_ir / 16 == 1);
        e.clra = ctl[5] && (m_ir / 16 == 2);
        sb.push_back(e);
        model_edge(ctl, le, int'(la), int'(ldt), clr);
    endtask

    task automatic cyc(input logic [7:0] ctl);
        cyx(ctl, 1'b0, 4'h0, 8'h00, 1'b0);
    endtask

    task automatic ld(input logic [3:0] a, input logic [7:0] d);
        cyx(8'h00, 1'b1, a, d, 1'b0);
    endtask

    // Controller emulation: B, C, D, E then F or G depending on the decoded opcode
    task automatic run_instr();
        cyc(K_C3);
        cyc(K_C4);
        cyc(K_C42);
        cyc(K_C2 | K_C7);
        if (m_ir / 16 == 1) cyc(K_C9);
        else if (m_ir / 16 == 2) cyc(K_C8);
    endtask

    initial begin
        int waited;
        logic [7:0] rc;
        CLR = 1'b1;
        {C0, C2, C3, C4, C42, C7, C8, C9} = 8'h00;
        ld_en = 1'b0; ld_addr = 4'h0; ld_data = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        model_clear();

        cyx(8'h00, 1'b0, 4'h0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) ld(4'(i), 8'($urandom_range(0, 255)));

        // Reset mid-cycle from acc=0x37, pc=5
        repeat (55) cyc(K_C9);
        repeat (5) cyc(K_C2);
        cyx(8'h00, 1'b0, 4'h0, 8'h00, 1'b1);
        cyc(8'h00);

        // INC program: three increments then a clear
        ld(4'd0, 8'h10); ld(4'd1, 8'h10); ld(4'd2, 8'h10); ld(4'd3, 8'h20);
        repeat (4) run_instr();
        cyc(8'h00);

        // Accumulator wrap, carry clear, PC wrap
        cyc(K_C8);
        repeat (256) cyc(K_C9);
        cyc(8'h00);
        cyc(K_C8);
        cyc(8'h00);
        while (m_pc != 15) cyc(K_C2);
        cyc(K_C2);
        cyc(8'h00);

        // Priority between clears and increment
        cyc(K_C0);
        repeat (4) cyc(K_C9);
        cyc(K_C0 | K_C9);
        cyc(8'h00);
        repeat (3) cyc(K_C9);
        cyc(K_C8 | K_C9);
        cyc(8'h00);

        // Read-before-write on the same address
        ld(4'd2, 8'h10);
        cyc(K_C0);
        cyc(K_C2); cyc(K_C2);
        cyc(K_C3);
        cyx(K_C4, 1'b1, 4'd2, 8'h20, 1'b0);
        cyc(K_C42);
        cyc(K_C4);
        cyc(K_C42);
        cyc(8'h00);

        // NOP opcode leaves ACC alone
        ld(4'd3, 8'h30);
        cyc(K_C0);
        repeat (3) cyc(K_C2);
        cyc(K_C9);
        run_instr();
        cyc(8'h00);

        // Random control words and loads
        repeat (400) begin
            rc = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) != 0) rc[0] = 1'b0;
            cyx(rc, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)), 1'b0);
        end
        cyc(8'h00);

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #3;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
